// File: rtl/impor_host.sv
// impor_host -- host-side driver for the 3x3 grid-transform engine.
//
// Latches one grid (nine 3-bit cells) plus a command list, streams the grid
// and the commands to the engine, then gathers the nine returned cells into
// a 27-bit result word.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request a transaction (sampled only in IDLE)
//   grid_in[26:0]     cell k = grid_in[3k+2:3k], row-major, k=0 top-left
//   cmd_list          command j = cmd_list[3j+2:3j]
//   cmd_cnt[3:0]      number of commands, clamped to MAX_CMDS
//   dev_in/dev_mode/dev_in_valid   serial stream towards the engine
//   dev_ready         engine ready to accept a grid
//   dev_out/dev_out_valid          result cells from the engine
//   busy, done, result, err_timeout  status / result towards the user
//
// Optional build macro IMPOR_HOST_CHECK_EN adds an internal golden model
// with outputs mismatch and exp_result.
//
// State   | meaning
// IDLE      waiting for start
// WAIT_RDY  waiting for dev_ready (timeout guarded)
// SEND_GRID cells 1..8 on the wire (cell 0 launched from WAIT_RDY)
// SEND_CMD  one command per cycle
// SEND_END  mode-0 terminator
// COLLECT   gathering nine result cells (timeout guarded)
// DONE      done pulse cycle; start is ignored here
module impor_host #(
  parameter int MAX_CMDS = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [26:0]           grid_in,
  input  logic [3*MAX_CMDS-1:0] cmd_list,
  input  logic [3:0]            cmd_cnt,
  output logic [2:0]            dev_in,
  output logic [2:0]            dev_mode,
  output logic                  dev_in_valid,
  input  logic                  dev_ready,
  input  logic [2:0]            dev_out,
  input  logic                  dev_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [26:0]           result,
  output logic                  err_timeout
`ifdef IMPOR_HOST_CHECK_EN
  ,
  output logic                  mismatch,
  output logic [26:0]           exp_result
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, SEND_GRID, SEND_CMD, SEND_END, COLLECT, DONE
  } state_t;

  state_t        state;
  logic [26:0]   grid_q;
  logic [26:0]   stage;
  logic [2:0]    cmd_q [16];
  logic [3:0]    idx;
  logic [3:0]    cidx;
  logic [3:0]    cidx_nx;
  logic [TW-1:0] tmr;
  logic [47:0]   cmd_pad;
  logic [3:0]    cnt_c;
  logic [2:0]    cell_sel;
  logic [26:0]   stage_nx;

  // Commands are held in a 16-deep table; slots at or beyond the clamped
  // count are zero, so a zero entry is the single end-of-list condition.
  assign cmd_pad = 48'(cmd_list);
  assign cnt_c   = (cmd_cnt > 4'(MAX_CMDS)) ? 4'(MAX_CMDS) : cmd_cnt;
  assign cidx_nx = cidx + 4'd1;

  always_comb begin
    cell_sel = 3'd0;
    stage_nx = stage;
    for (int k = 0; k < 9; k++) begin
      if (idx == 4'(k)) begin
        cell_sel = grid_q[3*k +: 3];
        stage_nx[3*k +: 3] = dev_out;
      end
    end
  end

`ifdef IMPOR_HOST_CHECK_EN
  function automatic logic [26:0] xform(input logic [26:0] g, input logic [2:0] op);
    logic [2:0]  o [9];
    logic [2:0]  n [9];
    logic [26:0] p;
    for (int k = 0; k < 9; k++) o[k] = g[3*k +: 3];
    n = o;
    case (op)
      3'd1: for (int r = 0; r < 3; r++) begin
        n[3*r]   = o[3*r+2];
        n[3*r+2] = o[3*r];
      end
      3'd2: for (int c = 0; c < 3; c++) begin
        n[c]   = o[c+6];
        n[c+6] = o[c];
      end
      3'd3: begin
        n[0] = o[2]; n[1] = o[5]; n[2] = o[8]; n[3] = o[1];
        n[5] = o[7]; n[6] = o[0]; n[7] = o[3]; n[8] = o[6];
      end
      3'd4: begin
        n[0] = o[6]; n[1] = o[3]; n[2] = o[0]; n[3] = o[7];
        n[5] = o[1]; n[6] = o[8]; n[7] = o[5]; n[8] = o[2];
      end
      3'd5, 3'd6, 3'd7: for (int k = 0; k < 9; k++) begin
        if ((k % 3) == (int'(op) - 5) && o[k] != 3'd7) n[k] = o[k] + 3'd1;
      end
      default: ;
    endcase
    p = '0;
    for (int k = 0; k < 9; k++) p[3*k +: 3] = n[k];
    return p;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grid_q       <= '0;
      stage        <= '0;
      idx          <= '0;
      cidx         <= '0;
      tmr          <= '0;
      dev_in       <= '0;
      dev_mode     <= '0;
      dev_in_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      err_timeout  <= 1'b0;
      for (int j = 0; j < 16; j++) cmd_q[j] <= '0;
`ifdef IMPOR_HOST_CHECK_EN
      mismatch     <= 1'b0;
      exp_result   <= '0;
`endif
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (start) begin
          grid_q <= grid_in;
          for (int j = 0; j < 16; j++)
            cmd_q[j] <= (4'(j) < cnt_c) ? cmd_pad[3*j +: 3] : 3'd0;
          busy  <= 1'b1;
          tmr   <= TW'(TIMEOUT);
          stage <= '0;
          idx   <= '0;
          cidx  <= '0;
          state <= WAIT_RDY;
`ifdef IMPOR_HOST_CHECK_EN
          exp_result <= grid_in;
          mismatch   <= 1'b0;
`endif
        end
        WAIT_RDY: begin
          if (dev_ready) begin
            // Cell 0 goes out on the transition edge so the grid starts
            // the cycle SEND_GRID is entered.
            dev_in       <= grid_q[2:0];
            dev_in_valid <= 1'b1;
            idx          <= 4'd1;
            state        <= SEND_GRID;
          end else if (tmr == TW'(1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        SEND_GRID: begin
          dev_in <= cell_sel;
          idx    <= idx + 4'd1;
          if (idx == 4'd8) state <= (cmd_q[0] == 3'd0) ? SEND_END : SEND_CMD;
        end
        SEND_CMD: begin
          dev_in       <= '0;
          dev_in_valid <= 1'b0;
          dev_mode     <= cmd_q[cidx];
          cidx         <= cidx_nx;
`ifdef IMPOR_HOST_CHECK_EN
          exp_result   <= xform(exp_result, cmd_q[cidx]);
`endif
          if (cmd_q[cidx_nx] == 3'd0) state <= SEND_END;
        end
        SEND_END: begin
          dev_in       <= '0;
          dev_in_valid <= 1'b0;
          dev_mode     <= '0;
          idx          <= '0;
          tmr          <= TW'(TIMEOUT);
          state        <= COLLECT;
        end
        COLLECT: begin
          if (dev_out_valid) begin
            stage <= stage_nx;
            idx   <= idx + 4'd1;
            tmr   <= TW'(TIMEOUT);
            if (idx == 4'd8) begin
              result <= stage_nx;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
`ifdef IMPOR_HOST_CHECK_EN
              mismatch <= (stage_nx != exp_result);
`endif
            end
          end else if (tmr == TW'(1)) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_impor_host.sv
module tb_impor_host;
  localparam int MAXC = 8;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [26:0] grid_in;
  logic [23:0] cmd_list;
  logic [3:0]  cmd_cnt;
  logic [2:0]  dev_in, dev_mode, dev_out;
  logic        dev_in_valid, dev_ready, dev_out_valid;
  logic        busy, done, err_timeout;
  logic [26:0] result;

  impor_host #(.MAX_CMDS(MAXC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .grid_in(grid_in),
    .cmd_list(cmd_list), .cmd_cnt(cmd_cnt), .dev_in(dev_in),
    .dev_mode(dev_mode), .dev_in_valid(dev_in_valid), .dev_ready(dev_ready),
    .dev_out(dev_out), .dev_out_valid(dev_out_valid), .busy(busy),
    .done(done), .result(result), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  tcyc  = 0;
  bit  chk_on = 1'b0;

  logic        e_v    [256];
  logic [2:0]  e_in   [256];
  logic [2:0]  e_mode [256];
  logic        e_busy [256];
  logic        e_done [256];
  logic        e_err  [256];
  logic [26:0] e_res  [256];
  logic [26:0] prev_res = '0;

  localparam logic [26:0] G1 = 27'o107654321;

  task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got 'h%0h expected 'h%0h", nm, tcyc, act, exp);
    end
  endtask

  // Engine contract on a 3x3 view: (r,c) = cell 3r+c.
  function automatic logic [26:0] xf(input logic [26:0] g, input logic [2:0] op);
    logic [2:0]  a [3][3];
    logic [2:0]  b [3][3];
    logic [26:0] o;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) a[r][c] = g[3*(3*r+c) +: 3];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        case (op)
          3'd1: b[r][c] = a[r][2-c];
          3'd2: b[r][c] = a[2-r][c];
          3'd3: b[r][c] = a[c][2-r];
          3'd4: b[r][c] = a[2-c][r];
          default: b[r][c] = (c == int'(op) - 5 && a[r][c] != 3'd7) ? a[r][c] + 3'd1 : a[r][c];
        endcase
      end
    o = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) o[3*(3*r+c) +: 3] = b[r][c];
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("dev_in_valid", 27'(dev_in_valid), 27'(e_v[tcyc]));
      chk("dev_in",       27'(dev_in),       27'(e_in[tcyc]));
      chk("dev_mode",     27'(dev_mode),     27'(e_mode[tcyc]));
      chk("busy",         27'(busy),         27'(e_busy[tcyc]));
      chk("done",         27'(done),         27'(e_done[tcyc]));
      chk("err_timeout",  27'(err_timeout),  27'(e_err[tcyc]));
      chk("result",       result,            e_res[tcyc]);
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_dev_in"},   27'(dev_in), '0);
    chk({pfx, "_dev_mode"}, 27'(dev_mode), '0);
    chk({pfx, "_valid"},    27'(dev_in_valid), '0);
    chk({pfx, "_busy"},     27'(busy), '0);
    chk({pfx, "_done"},     27'(done), '0);
    chk({pfx, "_err"},      27'(err_timeout), '0);
    chk({pfx, "_result"},   result, '0);
  endtask

  // One transaction. rd: wait cycles before dev_ready; gap: idle cycles
  // between result beats; nb: beats returned; never: dev_ready stays low;
  // rst_at: cycle to pull reset (-1 = none). Called and returns at posedge+1.
  task automatic run_txn(input logic [26:0] g, input logic [23:0] cl, input int cnt,
                         input int rd, input int gap, input int nb, input bit never,
                         input int rst_at);
    logic [2:0]  eff [8];
    logic [26:0] res;
    int m, cc, t0, te, len, lim;
    bit stop;
    m = 0; stop = 1'b0;
    cc = (cnt > MAXC) ? MAXC : cnt;
    for (int j = 0; j < cc; j++) begin
      if (!stop) begin
        if (cl[3*j +: 3] == 3'd0) stop = 1'b1;
        else begin eff[m] = cl[3*j +: 3]; m++; end
      end
    end
    res = g;
    for (int j = 0; j < m; j++) res = xf(res, eff[j]);
    t0 = 12 + rd + m;

    for (int t = 0; t < 256; t++) begin
      e_v[t] = 0; e_in[t] = 0; e_mode[t] = 0; e_busy[t] = 0;
      e_done[t] = 0; e_err[t] = 0; e_res[t] = prev_res;
    end
    if (never) begin
      te = TMO + 1; len = te + 2; lim = te - 1;
      e_err[te] = 1'b1;
    end else begin
      for (int k = 0; k < 9; k++) begin
        e_v[2+rd+k]  = 1'b1;
        e_in[2+rd+k] = g[3*k +: 3];
      end
      for (int j = 0; j < m; j++) e_mode[11+rd+j] = eff[j];
      if (nb == 9) begin
        te = t0 + 8*(gap+1) + 1; len = te + 2; lim = te;
        e_done[te] = 1'b1;
        for (int t = te; t < 256; t++) e_res[t] = res;
      end else begin
        te = t0 + (nb-1)*(gap+1) + TMO + 1; len = te + 2; lim = te - 1;
        e_err[te] = 1'b1;
      end
    end
    for (int t = 1; t < te; t++) e_busy[t] = 1'b1;

    for (int t = 0; t < len; t++) begin
      if (t == 0) begin
        start = 1'b1; grid_in = g; cmd_list = cl; cmd_cnt = 4'(cnt);
      end else begin
        start    = (t <= lim) ? 1'($urandom_range(0, 1)) : 1'b0;
        grid_in  = 27'($urandom);
        cmd_list = 24'($urandom);
        cmd_cnt  = 4'($urandom);
      end
      dev_ready     = !never && (t >= 1 + rd);
      dev_out_valid = 1'b0;
      dev_out       = 3'($urandom);
      if (!never) begin
        for (int k = 0; k < nb; k++)
          if (t == t0 + k*(gap+1)) begin dev_out_valid = 1'b1; dev_out = res[3*k +: 3]; end
        if (nb == 9 && t == te) dev_out_valid = 1'b1;
      end
      tcyc = t;
      chk_on = 1'b1;
      if (t == rst_at) begin
        #2;
        chk_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("rst_mid");
        start = 1'b0; dev_ready = 1'b0; dev_out_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        prev_res = '0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    chk_on = 1'b0;
    start = 1'b0; dev_ready = 1'b0; dev_out_valid = 1'b0;
    if (!never && nb == 9) prev_res = res;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; grid_in = '0; cmd_list = '0; cmd_cnt = '0;
    dev_ready = 1'b0; dev_out = '0; dev_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_lr",     xf(G1, 3'd1), 27'o701456123);
    chk("model_cw",     xf(G1, 3'd4), 27'o361250147);
    chk("model_ccw_cw", xf(xf(G1, 3'd3), 3'd4), G1);
    chk("model_sat",    xf(xf(xf(27'o777777777, 3'd5), 3'd6), 3'd7), 27'o777777777);

    run_txn(G1, 24'o1, 1, 2, 0, 9, 1'b0, -1);
    chk("res_lr_lit", result, 27'o701456123);
    run_txn(G1, 24'o43, 2, 0, 1, 9, 1'b0, -1);
    chk("res_ccw_cw_lit", result, G1);
    run_txn(G1, 24'o4, 1, 1, 0, 9, 1'b0, -1);
    chk("res_cw_lit", result, 27'o361250147);
    run_txn(27'o777777777, 24'o765, 3, 0, 0, 9, 1'b0, -1);
    run_txn(G1, 24'o0, 0, 0, 0, 9, 1'b0, -1);
    run_txn(G1, 24'o102, 3, 0, 0, 9, 1'b0, -1);
    run_txn(G1, 24'o1, 1, 0, 0, 9, 1'b1, -1);
    run_txn(G1, 24'o1234, 4, 0, 5, 9, 1'b0, -1);
    run_txn(G1, 24'o12341234, 12, 0, 0, 9, 1'b0, -1);
    run_txn(G1, 24'o21, 2, 1, 2, 4, 1'b0, -1);
    run_txn(G1, 24'o3412, 4, 0, 0, 9, 1'b0, 13);
    run_txn(G1, 24'o3412, 4, 0, 0, 9, 1'b0, -1);

    for (int i = 0; i < 15; i++)
      run_txn(27'($urandom), 24'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 9, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
